// File: rtl/line_burst_adapter_if.sv
// Cache-line and memory-burst signal bundle for line_burst_adapter.
// The slave modport is the adapter's view; the master modport is the cache and memory side.
interface line_burst_adapter_if #(
    parameter int S_OFFSET    = 5,
    parameter int BURST_WIDTH = 64
);
    localparam int SIZE = (2 ** S_OFFSET) * 8;

    logic                   read_i;
    logic                   write_i;
    logic [31:0]            address_i;
    logic [SIZE-1:0]        line_i;
    logic [SIZE-1:0]        line_o;
    logic                   resp_o;
    logic [31:0]            address_o;
    logic                   read_o;
    logic                   write_o;
    logic [BURST_WIDTH-1:0] burst_i;
    logic [BURST_WIDTH-1:0] burst_o;
    logic                   resp_i;

    modport slave (
        input  read_i, write_i, address_i, line_i, burst_o, resp_i,
        output line_o, resp_o, address_o, read_o, write_o, burst_i
    );

    modport master (
        output read_i, write_i, address_i, line_i, burst_o, resp_i,
        input  line_o, resp_o, address_o, read_o, write_o, burst_i
    );
endinterface

// File: rtl/line_burst_adapter.sv
// Turns whole-line cache read/write requests into fixed-length ascending memory bursts
// and returns a one-cycle response with the assembled read line.
module line_burst_adapter #(
    parameter int S_OFFSET    = 5,
    parameter int BURST_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    line_burst_adapter_if.slave   bus
);
    localparam int SIZE  = (2 ** S_OFFSET) * 8;
    localparam int BEATS = SIZE / BURST_WIDTH;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [31:0] ADDR_MASK = ~((32'd1 << S_OFFSET) - 32'd1);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t           r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [31:0]      r_addr, w_addr_next;
    logic [SIZE-1:0]  r_wline, w_wline_next;
    logic [SIZE-1:0]  r_rline, w_rline_next;

    logic [BURST_WIDTH-1:0] w_beats [BEATS];

    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_beat
            assign w_beats[gi] = r_wline[gi*BURST_WIDTH +: BURST_WIDTH];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wline <= '0;
            r_rline <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_addr  <= w_addr_next;
            r_wline <= w_wline_next;
            r_rline <= w_rline_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_addr_next  = r_addr;
        w_wline_next = r_wline;
        w_rline_next = r_rline;
        case (r_state)
            IDLE: begin
                // Write wins when both requests arrive together.
                if (bus.write_i) begin
                    w_addr_next  = bus.address_i & ADDR_MASK;
                    w_wline_next = bus.line_i;
                    w_cnt_next   = '0;
                    w_state_next = WR;
                end else if (bus.read_i) begin
                    w_addr_next  = bus.address_i & ADDR_MASK;
                    w_cnt_next   = '0;
                    w_state_next = RD;
                end
            end
            RD: begin
                if (bus.resp_i) begin
                    for (int b = 0; b < BEATS; b++) begin
                        if (r_cnt == CNT_W'(b)) begin
                            w_rline_next[b*BURST_WIDTH +: BURST_WIDTH] = bus.burst_o;
                        end
                    end
                    w_cnt_next = r_cnt + 1'b1;
                    if (r_cnt == LAST_BEAT) begin
                        w_state_next = DONE;
                    end
                end
            end
            WR: begin
                if (bus.resp_i) begin
                    w_cnt_next = r_cnt + 1'b1;
                    if (r_cnt == LAST_BEAT) begin
                        w_state_next = DONE;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Memory-side outputs depend on registered state only, never on cache inputs.
    assign bus.read_o    = (r_state == RD);
    assign bus.write_o   = (r_state == WR);
    assign bus.address_o = ((r_state == RD) || (r_state == WR)) ? r_addr : 32'd0;
    assign bus.burst_i   = (r_state == WR) ? w_beats[r_cnt] : '0;
    assign bus.resp_o    = (r_state == DONE);
    assign bus.line_o    = r_rline;
endmodule

// File: tb/tb_line_burst_adapter.sv
// Directed and randomized checks of line_burst_adapter against a line-level memory model.
module tb_line_burst_adapter;
    localparam int S_OFFSET = 5;
    localparam int BW       = 64;
    localparam int SIZE     = 256;
    localparam logic [31:0] MASK = 32'hFFFF_FFE0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic [SIZE-1:0] last_line = '0;

    line_burst_adapter_if #(.S_OFFSET(S_OFFSET), .BURST_WIDTH(BW)) bus ();

    line_burst_adapter #(.S_OFFSET(S_OFFSET), .BURST_WIDTH(BW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [SIZE-1:0] rand256();
        logic [SIZE-1:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [SIZE-1:0] obs, input logic [SIZE-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cache transaction; memory acks follow pat[0..plen-1], then random with stalls.
    task automatic do_txn(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [SIZE-1:0] data, input logic [31:0] pat,
                          input int plen, input bit hold, output int n_active);
        int beat = 0;
        int cyc  = 0;
        bit ack;
        n_active = 0;
        bus.read_i    = rd;
        bus.write_i   = wr;
        bus.address_i = addr;
        bus.line_i    = data;
        bus.resp_i    = 1'b0;
        @(negedge clk);
        bus.address_i = $urandom;
        bus.line_i    = rand256();
        while (beat < 4 && cyc < 200) begin
            chk("read_o", bus.read_o, !wr);
            chk("write_o", bus.write_o, wr);
            chk("address_o", bus.address_o, addr & MASK);
            if (wr) chk("burst_i", bus.burst_i, data[beat*BW +: BW]);
            n_active++;
            ack = (cyc < plen) ? pat[cyc] : ($urandom_range(0, 3) != 0);
            bus.resp_i  = ack;
            bus.burst_o = wr ? BW'($urandom) : data[beat*BW +: BW];
            if (ack) beat++;
            cyc++;
            @(negedge clk);
        end
        chk("beats_done", beat, 4);
        bus.resp_i = 1'b0;
        chk("resp_o_pulse", bus.resp_o, 1'b1);
        chk("req_dropped", {bus.read_o, bus.write_o}, 2'b00);
        if (!wr) last_line = data;
        chk("line_o", bus.line_o, last_line);
        $display("txn rd=%0b wr=%0b addr=%h active=%0d", rd, wr, addr, n_active);
        if (!hold) begin
            bus.read_i  = 1'b0;
            bus.write_i = 1'b0;
            @(negedge clk);
            chk("resp_o_once", bus.resp_o, 1'b0);
            chk("idle_after", {bus.read_o, bus.write_o}, 2'b00);
        end
    endtask

    initial begin
        int n;
        logic [SIZE-1:0] d;
        bus.read_i = 0; bus.write_i = 0; bus.address_i = 0; bus.line_i = 0;
        bus.burst_o = 0; bus.resp_i = 0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_read_o", bus.read_o, 1'b0);
        chk("rst_write_o", bus.write_o, 1'b0);
        chk("rst_resp_o", bus.resp_o, 1'b0);
        chk("rst_address_o", bus.address_o, 32'd0);
        chk("rst_burst_i", bus.burst_i, 64'd0);
        chk("rst_line_o", bus.line_o, '0);
        rst = 1'b0;
        @(negedge clk);

        // Aligned read, no stalls
        d = {64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222,
             64'h1111_1111_1111_1111, 64'h0000_0000_0000_0001};
        do_txn(1, 0, 32'h0000_1234, d, 32'hF, 4, 0, n);
        chk("read_cycles", n, 4);

        // Stalled write: acks 1,0,0,1,1,0,1
        d = rand256();
        do_txn(0, 1, 32'hABCD_00FF, d, 32'b1011001, 7, 0, n);
        chk("write_cycles", n, 7);

        // Simultaneous read and write -> write only
        d = rand256();
        do_txn(1, 1, 32'h0000_4040, d, 32'hF, 4, 0, n);
        chk("both_cycles", n, 4);

        // Held read: one extra burst after one IDLE cycle
        d = rand256();
        do_txn(1, 0, 32'h1000_0020, d, 32'hF, 4, 1, n);
        @(negedge clk);
        chk("held_idle_resp", bus.resp_o, 1'b0);
        chk("held_idle_req", {bus.read_o, bus.write_o}, 2'b00);
        d = rand256();
        do_txn(1, 0, 32'h1000_0020, d, 32'hF, 4, 0, n);
        chk("held_cycles", n, 4);
        @(negedge clk);
        chk("held_no_third", bus.read_o, 1'b0);

        // Spurious resp_i while IDLE
        for (int i = 0; i < 3; i++) begin
            bus.resp_i  = 1'b1;
            bus.burst_o = BW'($urandom);
            @(negedge clk);
            chk("spur_req", {bus.read_o, bus.write_o, bus.resp_o}, 3'b000);
            chk("spur_line", bus.line_o, last_line);
        end
        bus.resp_i = 1'b0;
        d = rand256();
        do_txn(0, 1, 32'h0000_0007, d, 32'hF, 4, 0, n);

        // Reset mid-read burst
        bus.read_i = 1'b1;
        bus.address_i = 32'h5555_5555;
        @(negedge clk);
        chk("mid_read_o", bus.read_o, 1'b1);
        bus.resp_i = 1'b1;
        bus.burst_o = 64'hDEAD_BEEF_0000_0001;
        repeat (2) @(negedge clk);
        rst = 1'b1; bus.read_i = 1'b0; bus.resp_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("mrst_req", {bus.read_o, bus.write_o, bus.resp_o}, 3'b000);
            chk("mrst_addr", bus.address_o, 32'd0);
            chk("mrst_line", bus.line_o, '0);
        end
        rst = 1'b0;
        last_line = '0;
        @(negedge clk);
        chk("mrst_no_resp", bus.resp_o, 1'b0);
        d = rand256();
        do_txn(1, 0, 32'h0000_8888, d, 32'hF, 4, 0, n);

        // Randomized transactions with random stalls
        for (int t = 0; t < 12; t++) begin
            bit w;
            w = $urandom_range(0, 1) == 1;
            d = rand256();
            do_txn(!w, w, $urandom, d, 32'd0, 0, 0, n);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
